// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_pkg
//  Description : Shared datapath constants for the CPU register file and
//                the stages that consume it.
//  Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    // Default datapath geometry
    localparam int c_WIDTH  = 16;
    localparam int c_DEPTH  = 8;
    localparam int c_ADDR_W = 3;

    // Write-counter geometry; the counter sticks at its maximum
    localparam int         c_CNT_W   = 8;
    localparam logic [7:0] c_CNT_MAX = 8'hFF;

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/reg_en.sv
`default_nettype none
// ============================================================================
//  Module      : reg_en
//  Description : WIDTH-bit edge-triggered register with load enable and
//                asynchronous active-low clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module reg_en #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear immediately on reset; otherwise load only when enabled
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg_en
`default_nettype wire

// File: rtl/cpu_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : cpu_reg_file
//  Description : DEPTH x WIDTH register file, one write port and two
//                combinational read ports. R0 is hardwired to zero. Counts
//                accepted writes in a saturating 8-bit counter.
//  Revision    : 1.0 - initial release
// ============================================================================
module cpu_reg_file
    import cpu_pkg::*;
#(
    parameter int WIDTH  = c_WIDTH,
    parameter int DEPTH  = c_DEPTH,
    parameter int ADDR_W = c_ADDR_W
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr_a,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_a,
    output logic [WIDTH-1:0]  rdata_b,
    output logic [7:0]        wr_count
);

    // A write counts only when it targets a real (non-zero) register
    logic w_accept;
    assign w_accept = we && (waddr != '0);

    // Register outputs; entry 0 is the constant-zero R0
    logic [WIDTH-1:0] w_rq [DEPTH];
    logic [DEPTH-1:1] w_wen;

    assign w_rq[0] = '0;

    // One enabled register per writable index, with a one-hot write decode
    generate
        for (genvar gi = 1; gi < DEPTH; gi++) begin : g_regs
            assign w_wen[gi] = w_accept && (waddr == ADDR_W'(gi));

            reg_en #(
                .WIDTH (WIDTH)
            ) u_reg (
                .clk    (clk),
                .resetn (resetn),
                .i_en   (w_wen[gi]),
                .i_d    (wdata),
                .o_q    (w_rq[gi])
            );
        end
    endgenerate

    // Read ports return the stored (pre-edge) value; no write bypass
    assign rdata_a = w_rq[raddr_a];
    assign rdata_b = w_rq[raddr_b];

    logic [c_CNT_W-1:0] r_wr_count;

    // Saturating count of accepted writes, cleared asynchronously
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_wr_count <= '0;
        end else if (w_accept && (r_wr_count != c_CNT_MAX)) begin
            r_wr_count <= r_wr_count + 8'd1;
        end
    end

    assign wr_count = r_wr_count;

endmodule : cpu_reg_file
`default_nettype wire

// File: tb/tb_cpu_reg_file.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cpu_reg_file
//  Description : Directed self-checking bench for cpu_reg_file.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cpu_reg_file;

    localparam int c_WIDTH  = 16;
    localparam int c_ADDR_W = 3;

    logic                clk;
    logic                resetn;
    logic                we;
    logic [c_ADDR_W-1:0] waddr;
    logic [c_WIDTH-1:0]  wdata;
    logic [c_ADDR_W-1:0] raddr_a;
    logic [c_ADDR_W-1:0] raddr_b;
    logic [c_WIDTH-1:0]  rdata_a;
    logic [c_WIDTH-1:0]  rdata_b;
    logic [7:0]          wr_count;

    int r_tests = 0;
    int r_fails = 0;

    cpu_reg_file #(
        .WIDTH  (16),
        .DEPTH  (8),
        .ADDR_W (3)
    ) u_dut (
        .clk      (clk),
        .resetn   (resetn),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr_a  (raddr_a),
        .raddr_b  (raddr_b),
        .rdata_a  (rdata_a),
        .rdata_b  (rdata_b),
        .wr_count (wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it if the values differ
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        r_tests++;
        if (got !== exp) begin
            r_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single write cycle, then drop write enable
    task automatic wr(input logic [2:0] a, input logic [15:0] d);
        we = 1'b1; waddr = a; wdata = d;
        tick();
        we = 1'b0;
    endtask

    // Read a register through port A
    task automatic rd_a(input logic [2:0] a, input string tag, input logic [15:0] exp);
        raddr_a = a;
        #1;
        chk(tag, {16'h0, rdata_a}, {16'h0, exp});
    endtask

    logic [15:0] exp_regs [8];

    initial begin
        resetn = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr_a = 3'd3; raddr_b = 3'd7;
        for (int i = 0; i < 8; i++) exp_regs[i] = 16'h0;

        // Reset state
        #2;
        chk("reset_rdata_a", {16'h0, rdata_a}, 32'h0);
        chk("reset_rdata_b", {16'h0, rdata_b}, 32'h0);
        chk("reset_wr_count", {24'h0, wr_count}, 32'h0);
        tick();
        resetn = 1'b1;

        // Write 0xBEEF to R3; others read 0, one write counted
        wr(3'd3, 16'hBEEF);
        rd_a(3'd3, "r3_beef", 16'hBEEF);
        for (int i = 0; i < 8; i++) begin
            if (i != 3) rd_a(3'(i), "others_zero", 16'h0);
        end
        chk("count_after_first", {24'h0, wr_count}, 32'd1);

        // Writes to R0 are ignored and not counted
        wr(3'd0, 16'hFFFF);
        rd_a(3'd0, "r0_protect", 16'h0000);
        chk("r0_no_count", {24'h0, wr_count}, 32'd1);

        // Same-cycle read/write: old value before edge, new after
        wr(3'd5, 16'h1234);
        raddr_b = 3'd5; we = 1'b1; waddr = 3'd5; wdata = 16'h5678;
        #1;
        chk("r5_before_edge", {16'h0, rdata_b}, 32'h1234);
        tick();
        we = 1'b0;
        chk("r5_after_edge", {16'h0, rdata_b}, 32'h5678);
        chk("count_after_r5", {24'h0, wr_count}, 32'd3);

        // Dual read ports
        wr(3'd1, 16'h00AA);
        wr(3'd2, 16'h5500);
        raddr_a = 3'd1; raddr_b = 3'd2; #1;
        chk("dual_a", {16'h0, rdata_a}, 32'h00AA);
        chk("dual_b", {16'h0, rdata_b}, 32'h5500);
        raddr_a = 3'd2; #1;
        chk("same_idx_a", {16'h0, rdata_a}, 32'h5500);
        chk("same_idx_b", {16'h0, rdata_b}, 32'h5500);

        // we=0 with live-looking address/data changes nothing
        we = 1'b0; waddr = 3'd3; wdata = 16'h0000;
        tick();
        rd_a(3'd3, "we0_hold_r3", 16'hBEEF);

        // Saturation: 5 writes so far, 249 more reach 254, the rest stick at 255
        for (int i = 0; i < 249; i++) wr(3'd7, 16'(i));
        chk("count_254", {24'h0, wr_count}, 32'd254);
        for (int i = 249; i < 300; i++) wr(3'd7, 16'(i));
        chk("count_sat_255", {24'h0, wr_count}, 32'd255);
        rd_a(3'd7, "r7_last", 16'd299);

        // Ten idle cycles with random address/data: nothing moves
        exp_regs[1] = 16'h00AA; exp_regs[2] = 16'h5500; exp_regs[3] = 16'hBEEF;
        exp_regs[5] = 16'h5678; exp_regs[7] = 16'd299;
        for (int i = 0; i < 10; i++) begin
            we = 1'b0; waddr = 3'($urandom_range(0, 7)); wdata = 16'($urandom);
            tick();
        end
        for (int i = 0; i < 8; i++) rd_a(3'(i), "idle_hold", exp_regs[i]);
        chk("idle_count_255", {24'h0, wr_count}, 32'd255);

        // Mid-cycle asynchronous reset clears everything before the next edge
        raddr_a = 3'd3; raddr_b = 3'd7;
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_a", {16'h0, rdata_a}, 32'h0);
        chk("async_rst_b", {16'h0, rdata_b}, 32'h0);
        chk("async_rst_count", {24'h0, wr_count}, 32'h0);

        // Writes during reset are discarded
        wr(3'd4, 16'h4444);
        rd_a(3'd4, "write_in_reset", 16'h0);
        chk("count_in_reset", {24'h0, wr_count}, 32'h0);

        // First edge after release accepts the write
        resetn = 1'b1;
        wr(3'd4, 16'h4444);
        rd_a(3'd4, "first_after_release", 16'h4444);
        chk("count_after_release", {24'h0, wr_count}, 32'd1);

        $display("[TB] %0d tests run, %0d failed", r_tests, r_fails);
        $finish;
    end

endmodule : tb_cpu_reg_file
`default_nettype wire

// File: doc/cpu_reg_file.md
CPU_REG_FILE -- requirements
Module: cpu_reg_file

Interface
REQ-001 Parameter WIDTH, default 16, data word width in bits.
REQ-002 Parameter DEPTH, default 8, number of registers; SHALL be a power of two, minimum 2.
REQ-003 Parameter ADDR_W, default 3, register address width; SHALL equal log2(DEPTH).
REQ-004 clk  input  1  single clock; all state updates on the rising edge.
REQ-005 resetn  input  1  reset, asynchronous and active-low.
REQ-006 we  input  1  write enable, sampled on the rising clk edge.
REQ-007 waddr  input  ADDR_W  write register index.
REQ-008 wdata  input  WIDTH  write data.
REQ-009 raddr_a  input  ADDR_W  read port A register index.
REQ-010 raddr_b  input  ADDR_W  read port B register index.
REQ-011 rdata_a  output  WIDTH  read port A data.
REQ-012 rdata_b  output  WIDTH  read port B data.
REQ-013 wr_count  output  8  number of accepted writes, saturating.

Function
REQ-014 Storage: DEPTH registers of WIDTH bits, R0..R(DEPTH-1).
REQ-015 Write: on rising clk with we=1 and waddr!=0, R[waddr] SHALL take wdata; all other registers SHALL hold.
REQ-016 R0: SHALL read as all-zero at all times; a write to index 0 SHALL be ignored and SHALL NOT count.
REQ-017 we=0: no register SHALL change; wdata and waddr are don't-care.
REQ-018 Read: rdata_a = R[raddr_a] and rdata_b = R[raddr_b], combinational, zero-cycle latency from the address.
REQ-019 Read/write same index, same cycle: the read SHALL return the pre-edge (old) value; the new value SHALL be visible after the edge (no bypass).
REQ-020 Both read ports SHALL be independent; the same index on A and B SHALL return identical data.
REQ-021 wr_count SHALL increment by 1 on each accepted write (we=1, waddr!=0).
REQ-022 wr_count SHALL saturate at 255 and SHALL hold there until reset.
REQ-023 Write latency: data written at edge N SHALL be readable from edge N onward, i.e. one cycle after presentation.

Reset
REQ-024 resetn=0 SHALL immediately clear all registers and wr_count to 0, without waiting for clk.
REQ-025 While resetn=0, writes SHALL be ignored and rdata_a/rdata_b SHALL read 0.
REQ-026 Reset assertion in the same cycle as a write SHALL discard that write.
REQ-027 Release: the first write SHALL be accepted at the first rising clk edge on which resetn=1.

Structure
REQ-028 WIDTH, DEPTH and ADDR_W default constants SHALL live in a shared package, cpu_pkg, for the datapath and control stages.
REQ-029 Each register SHALL be one instance of the sub-module reg_en: a WIDTH-bit edge-triggered register with load enable and asynchronous active-low clear, sharing Q behaviour with the existing D flip-flop stage.
REQ-030 Write address decode and read multiplexers SHALL stay in cpu_reg_file; no latches SHALL be inferred.

Verification
REQ-031 Reset: resetn=0 mid-cycle with all registers loaded -> rdata_a=rdata_b=0 and wr_count=0 before the next clk edge.
REQ-032 Write/read: write 0xBEEF to R3, then raddr_a=3 -> rdata_a=0xBEEF; other registers read 0; wr_count=1.
REQ-033 R0 protect: we=1, waddr=0, wdata=0xFFFF -> rdata_a at index 0 stays 0x0000; wr_count unchanged.
REQ-034 Same-cycle read/write: R5=0x1234, write 0x5678 to R5 with raddr_b=5 -> rdata_b=0x1234 before the edge and 0x5678 after it.
REQ-035 Dual port: R1=0x00AA and R2=0x5500, raddr_a=1, raddr_b=2 -> 0x00AA / 0x5500; both ports at 2 -> 0x5500 / 0x5500.
REQ-036 Saturation: 300 accepted writes -> wr_count=255; we=0 for 10 cycles -> all registers and wr_count unchanged.
